hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 85 ++++++++
 tb/tb_hazard_stall_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use and HI/LO interlocks, branch flush, stall-cycle counter.
// Control outputs are combinational in the same cycle; the HI/LO busy tracker and counter are registered.
module hazard_stall_unit #(
    parameter int MULDIV_LAT = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  IFIDrs,
    input  logic [4:0]  IFIDrt,
    input  logic        IFIDUsesRt,
    input  logic        IDMulDivIssue,
    input  logic        IDReadHILO,
    input  logic        IDEXMemRead,
    input  logic [4:0]  IDEXWriteReg,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        MulDivBusy,
    output logic [15:0] StallCycles
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] LOAD_CNT = 5'(MULDIV_LAT - 1);

    state_t     state;
    logic [4:0] busy_cnt;
    logic       load_use;
    logic       hilo_stall;
    logic       issue_ok;

    assign MulDivBusy = (state == BUSY);

    // Register 0 is hardwired, so a pending write to it never creates a dependency.
    assign load_use = IDEXMemRead && (IDEXWriteReg != 5'd0) &&
                      ((IDEXWriteReg == IFIDrs) || (IFIDUsesRt && (IDEXWriteReg == IFIDrt)));

    assign hilo_stall = MulDivBusy && (IDReadHILO || IDMulDivIssue);
    assign issue_ok   = IDMulDivIssue && !BranchTaken && !load_use && !MulDivBusy;

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (Rst || BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (load_use || hilo_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            busy_cnt <= 5'd0;
        end else if (state == IDLE) begin
            if (issue_ok) begin
                state    <= BUSY;
                busy_cnt <= LOAD_CNT;
            end
        end else begin
            // A running countdown is never aborted by a branch; the unit is already committed.
            if (busy_cnt == 5'd0) begin
                state <= IDLE;
            end else begin
                busy_cnt <= busy_cnt - 5'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCycles <= 16'd0;
        end else if (!PCWrite && (StallCycles != 16'hFFFF)) begin
            StallCycles <= StallCycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized plus directed bench for hazard_stall_unit against an in-bench behavioural model.
module tb_hazard_stall_unit;

    localparam int LAT = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  IFIDrs, IFIDrt, IDEXWriteReg;
    logic        IFIDUsesRt, IDMulDivIssue, IDReadHILO, IDEXMemRead, BranchTaken;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy;
    logic [15:0] StallCycles;

    int n_checks = 0;
    int n_fail   = 0;
    int m_busy_left = 0;   // cycles of HI/LO occupancy still to come
    int m_stalls    = 0;
    bit cmp_en = 1'b0;

    hazard_stall_unit #(.MULDIV_LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst),
        .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFIDUsesRt(IFIDUsesRt),
        .IDMulDivIssue(IDMulDivIssue), .IDReadHILO(IDReadHILO),
        .IDEXMemRead(IDEXMemRead), .IDEXWriteReg(IDEXWriteReg),
        .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXBubble(IDEXBubble), .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        return IDEXMemRead && IDEXWriteReg != 0 &&
               (IDEXWriteReg == IFIDrs || (IFIDUsesRt && IDEXWriteReg == IFIDrt));
    endfunction

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
    function automatic logic [3:0] model_ctrl();
        bit hl;
        hl = (m_busy_left > 0) && (IDReadHILO || IDMulDivIssue);
        if (Rst || BranchTaken) return 4'b1111;
        if (model_lu() || hl)   return 4'b0001;
        return 4'b1100;
    endfunction

    always @(posedge Clk) begin
        logic [3:0] c;
        c = model_ctrl();
        if (Rst) begin
            m_busy_left = 0;
            m_stalls    = 0;
        end else begin
            if (!c[3] && m_stalls < 65535) m_stalls++;
            if (m_busy_left > 0) m_busy_left--;
            else if (IDMulDivIssue && !BranchTaken && !model_lu()) m_busy_left = LAT;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("ctrl", {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}, model_ctrl());
            chk("busy", MulDivBusy, (m_busy_left > 0));
            chk("stall_cnt", StallCycles, m_stalls);
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        IFIDrs = 0; IFIDrt = 0; IFIDUsesRt = 0; IDMulDivIssue = 0; IDReadHILO = 0;
        IDEXMemRead = 0; IDEXWriteReg = 0; BranchTaken = 0;
    endtask

    task automatic do_reset();
        Rst = 1; clear_in();
        cyc();
        Rst = 0;
    endtask

    initial begin
        Rst = 1; clear_in();
        IDEXMemRead = 1; IDEXWriteReg = 5; IFIDrs = 5;
        @(negedge Clk);
        chk("rst_ctrl", {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}, 4'b1111);
        cyc();
        @(negedge Clk);
        chk("rst_busy", MulDivBusy, 0);
        chk("rst_cnt", StallCycles, 0);
        cyc();
        Rst = 0; clear_in();
        cmp_en = 1'b1;

        // Random phase: small register space so dependencies are frequent.
        for (int i = 0; i < 3000; i++) begin
            Rst           = ($urandom_range(0, 99) == 0);
            IFIDrs        = 5'($urandom_range(0, 3));
            IFIDrt        = 5'($urandom_range(0, 3));
            IDEXWriteReg  = 5'($urandom_range(0, 3));
            IFIDUsesRt    = 1'($urandom_range(0, 1));
            IDEXMemRead   = ($urandom_range(0, 9) < 3);
            BranchTaken   = ($urandom_range(0, 9) == 0);
            IDMulDivIssue = ($urandom_range(0, 99) < 15);
            IDReadHILO    = ($urandom_range(0, 99) < 15);
            cyc();
        end

        // Load-use on rs stalls one cycle.
        do_reset();
        IDEXMemRead = 1; IDEXWriteReg = 8; IFIDrs = 8;
        @(negedge Clk);
        chk("lu_pcw", PCWrite, 0);
        chk("lu_ifw", IFIDWrite, 0);
        chk("lu_bub", IDEXBubble, 1);
        chk("lu_cnt0", StallCycles, 0);
        cyc(); clear_in();
        @(negedge Clk);
        chk("lu_cnt1", StallCycles, 1);

        // Writes to r0 and unused rt never stall.
        IDEXMemRead = 1; IDEXWriteReg = 0; IFIDrs = 0;
        @(negedge Clk);
        chk("r0_pcw", PCWrite, 1);
        cyc();
        IDEXWriteReg = 8; IFIDrs = 3; IFIDrt = 8; IFIDUsesRt = 0;
        @(negedge Clk);
        chk("rt_unused_pcw", PCWrite, 1);
        cyc(); clear_in();
        @(negedge Clk);
        chk("no_stall_cnt", StallCycles, 1);

        // Mult then MFHI: busy exactly LAT cycles, MFHI accepted afterwards.
        do_reset();
        IDMulDivIssue = 1;
        @(negedge Clk);
        chk("mul_issue_pcw", PCWrite, 1);
        cyc(); IDMulDivIssue = 0; IDReadHILO = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            chk("mul_busy", MulDivBusy, 1);
            chk("mfhi_pcw", PCWrite, 0);
            cyc();
        end
        @(negedge Clk);
        chk("mul_done_busy", MulDivBusy, 0);
        chk("mfhi_accept", PCWrite, 1);
        chk("mul_stalls", StallCycles, 8);
        cyc(); clear_in();

        // Branch overrides load-use.
        do_reset();
        IDEXMemRead = 1; IDEXWriteReg = 8; IFIDrs = 8; BranchTaken = 1; IDMulDivIssue = 1;
        @(negedge Clk);
        chk("br_ctrl", {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}, 4'b1111);
        cyc(); clear_in();
        @(negedge Clk);
        chk("br_cnt", StallCycles, 0);
        chk("br_no_busy", MulDivBusy, 0);

        // Reset in the middle of a countdown with stalls pending.
        do_reset();
        IDMulDivIssue = 1;
        cyc(); IDMulDivIssue = 0; IDReadHILO = 1;
        cyc(); cyc(); cyc();
        Rst = 1;
        @(negedge Clk);
        chk("mid_rst_ctrl", {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}, 4'b1111);
        chk("mid_rst_cnt_pre", StallCycles, 3);
        chk("mid_rst_busy_pre", MulDivBusy, 1);
        cyc(); Rst = 0; clear_in();
        @(negedge Clk);
        chk("mid_rst_busy", MulDivBusy, 0);
        chk("mid_rst_cnt", StallCycles, 0);

        // Counter saturation.
        IDEXMemRead = 1; IDEXWriteReg = 8; IFIDrs = 8;
        for (int k = 0; k < 65534; k++) cyc();
        @(negedge Clk);
        chk("sat_fffe", StallCycles, 16'hFFFE);
        cyc(); cyc(); cyc();
        @(negedge Clk);
        chk("sat_ffff", StallCycles, 16'hFFFF);
        clear_in();
        cyc();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
